scene_sequencer: RTL

Single-clock game-state controller that sequences the sprite layer stack. It advances an intro sequence once per video frame: countdown, logo slide-out, head rise and coin spawn, then a run loop. It also owns player lane selection. It produces every offset, flip and status value the background/logo/head/coin layers consume, sampling VGA vsync as a data input instead of clocking logic from it.

---
 rtl/scene_pkg.sv | 24 ++
 rtl/scene_sequencer_edge_sync.sv | 25 ++
 rtl/scene_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/scene_pkg.sv
// Shared types and default tuning constants for the scene sequencer and its bench.
package scene_pkg;

    typedef logic signed [11:0] offset_t;

    typedef enum logic [2:0] {
        COUNTDOWN  = 3'd0,
        LOGO_SLIDE = 3'd1,
        HEAD_RISE  = 3'd2,
        COIN_SPAWN = 3'd3,
        RUN        = 3'd4
    } scene_state_t;

    localparam int      DEF_COUNTDOWN_FRAMES = 5;
    localparam offset_t DEF_LOGO_STEP        = 12'sd30;
    localparam offset_t DEF_LOGO_END         = 12'sd640;
    localparam offset_t DEF_HEAD_START       = 12'sd180;
    localparam offset_t DEF_HEAD_STEP        = 12'sd17;
    localparam offset_t DEF_HEAD_END         = 12'sd50;
    localparam offset_t DEF_COIN_START       = -12'sd50;
    localparam offset_t DEF_COIN_MAX         = 12'sd40;
    localparam offset_t DEF_LANE_DX          = 12'sd100;

endpackage

// File: rtl/scene_sequencer_edge_sync.sv
// Two-flop synchronizer with a registered one-cycle rising-edge pulse and a level output.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic pulse
);

    logic [2:0] sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 3'b000;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[1:0], din};
            pulse <= sync[1] & ~sync[2];
        end
    end

    assign level = sync[1];

endmodule

// File: rtl/scene_sequencer.sv
// Frame-ticked intro/run sequencer for the sprite layers; lane behaviour selected by SCENE_LANE_LATCH_EN.
module scene_sequencer
    import scene_pkg::*;
#(
    parameter int      COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
    parameter offset_t LOGO_STEP        = DEF_LOGO_STEP,
    parameter offset_t LOGO_END         = DEF_LOGO_END,
    parameter offset_t HEAD_START       = DEF_HEAD_START,
    parameter offset_t HEAD_STEP        = DEF_HEAD_STEP,
    parameter offset_t HEAD_END         = DEF_HEAD_END,
    parameter offset_t COIN_START       = DEF_COIN_START,
    parameter offset_t COIN_MAX         = DEF_COIN_MAX,
    parameter offset_t LANE_DX          = DEF_LANE_DX
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESET,
    input  logic        vsync,
    input  logic        btn_l,
    input  logic        btn_r,
    output offset_t     logo_voffset,
    output offset_t     head_hoffset,
    output offset_t     head_voffset,
    output offset_t     coin_loc,
    output logic        coin_flip,
    output logic [2:0]  state,
    output logic [15:0] score
);

    logic         frame_tick, vsync_level;
    logic         l_level, l_pulse, r_level, r_pulse;
    logic [7:0]   count;
    scene_state_t cur;
    offset_t      logo_next, head_next;

    edge_sync u_vsync (.clk(CLK100MHZ), .rst(CPU_RESET), .din(vsync), .level(vsync_level), .pulse(frame_tick));
    edge_sync u_btn_l (.clk(CLK100MHZ), .rst(CPU_RESET), .din(btn_l), .level(l_level), .pulse(l_pulse));
    edge_sync u_btn_r (.clk(CLK100MHZ), .rst(CPU_RESET), .din(btn_r), .level(r_level), .pulse(r_pulse));

    assign logo_next = logo_voffset + LOGO_STEP;
    assign head_next = head_voffset - HEAD_STEP;
    assign state     = cur;

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            cur          <= COUNTDOWN;
            count        <= 8'(COUNTDOWN_FRAMES);
            logo_voffset <= '0;
            head_voffset <= HEAD_START;
            coin_loc     <= COIN_START;
            coin_flip    <= 1'b0;
            score        <= '0;
        end else if (frame_tick) begin
            case (cur)
                COUNTDOWN: begin
                    count <= count - 8'd1;
                    if (count == 8'd1) cur <= LOGO_SLIDE;
                end
                LOGO_SLIDE: begin
                    logo_voffset <= logo_next;
                    if (logo_next >= LOGO_END) cur <= HEAD_RISE;
                end
                HEAD_RISE: begin
                    head_voffset <= head_next;
                    if (head_next <= HEAD_END) cur <= COIN_SPAWN;
                end
                COIN_SPAWN: begin
                    coin_loc <= '0;
                    cur      <= RUN;
                end
                RUN: begin
                    coin_flip <= ~coin_flip;
                    if (coin_loc == COIN_MAX) begin
                        coin_loc <= '0;
                        score    <= score + 16'd1;
                    end else begin
                        coin_loc <= coin_loc + 12'sd1;
                    end
                end
                default: cur <= COUNTDOWN;
            endcase
        end
    end

`ifdef SCENE_LANE_LATCH_EN
    logic signed [1:0] lane, lane_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lane_next = lane;
        if (cur != RUN)
            lane_next = 2'sd0;
        else if (l_pulse && !r_pulse && lane != -2'sd1)
            lane_next = lane - 2'sd1;
        else if (r_pulse && !l_pulse && lane != 2'sd1)
            lane_next = lane + 2'sd1;
    end

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            lane         <= 2'sd0;
            head_hoffset <= '0;
        end else begin
            lane <= lane_next;
            case (lane_next)
                2'sd1:   head_hoffset <= LANE_DX;
                -2'sd1:  head_hoffset <= -LANE_DX;
                default: head_hoffset <= '0;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{vsync_level, l_level, r_level};
`else
    // Left wins when both buttons are held.
    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET)
            head_hoffset <= '0;
        else if (l_level)
            head_hoffset <= -LANE_DX;
        else if (r_level)
            head_hoffset <= LANE_DX;
        else
            head_hoffset <= '0;
    end

    logic unused_ok;
    assign unused_ok = ^{vsync_level, l_pulse, r_pulse};
`endif

endmodule
